// File: rtl/panda_risc_v_wbk_arbiter.sv
// panda_risc_v_wbk_arbiter
// Write-back arbiter for the Panda RISC-V execution unit. Picks one of the
// five result sources (0 ALU, 1 LSU, 2 CSR, 3 MUL, 4 DIV) per cycle. The
// grant (s_wbk_ready) is combinational. The register-file write and the
// retire pulse are registered and appear one cycle after the grant.
// Configuration macro: PANDA_RISC_V_WBK_RR_EN
//   defined   -> round-robin arbitration. The search starts after the last
//                granted index.
//   undefined -> fixed priority LSU > MUL > DIV > CSR > ALU.
module panda_risc_v_wbk_arbiter #(
    parameter int inst_id_width    = 4,
    parameter int simulation_delay = 1
)(
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [4:0]                 s_wbk_valid,
    output logic [4:0]                 s_wbk_ready,
    input  logic [24:0]                s_wbk_rd_id,
    input  logic [4:0]                 s_wbk_rd_vld,
    input  logic [159:0]               s_wbk_data,
    input  logic [5*inst_id_width-1:0] s_wbk_inst_id,
    output logic                       reg_file_wen,
    output logic [4:0]                 reg_file_waddr,
    output logic [31:0]                reg_file_wdata,
    output logic                       retire_valid,
    output logic [inst_id_width-1:0]   retire_inst_id,
    output logic [2:0]                 grant_src
);

    // The simulation delay has no meaning in hardware. A negative value
    // is always a configuration mistake.
    if (simulation_delay < 0) begin : g_bad_delay
        $error("simulation_delay must be non-negative");
    end

    logic                     gnt_vld_s;
    logic [2:0]               gnt_idx_s;
    logic [4:0]               sel_rd_id_s;
    logic                     sel_rd_vld_s;
    logic [31:0]              sel_data_s;
    logic [inst_id_width-1:0] sel_inst_id_s;
    logic                     sel_wen_s;

`ifdef PANDA_RISC_V_WBK_RR_EN
    logic [2:0] ptr_r;

    // Round-robin search: first valid source after the last granted index.
    always_comb begin
        logic [3:0] sum_v;
        logic [3:0] cand_v;
        gnt_vld_s = 1'b0;
        gnt_idx_s = 3'd0;
        sum_v     = 4'd0;
        cand_v    = 4'd0;
        for (int i = 1; i <= 5; i++) begin
            sum_v  = {1'b0, ptr_r} + 4'(i);
            cand_v = (sum_v >= 4'd5) ? (sum_v - 4'd5) : sum_v;
            if (!gnt_vld_s && s_wbk_valid[cand_v[2:0]]) begin
                gnt_vld_s = 1'b1;
                gnt_idx_s = cand_v[2:0];
            end else begin
                // an earlier candidate already won, or this one is idle
            end
        end
    end

    // The pointer remembers the last granted source. It advances only on a transfer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_r <= 3'd4;
        end else if (gnt_vld_s) begin
            ptr_r <= gnt_idx_s;
        end
    end
`else
    // Fixed priority: LSU > MUL > DIV > CSR > ALU.
    always_comb begin
        gnt_vld_s = 1'b1;
        gnt_idx_s = 3'd0;
        if (s_wbk_valid[1]) begin
            gnt_idx_s = 3'd1;
        end else if (s_wbk_valid[3]) begin
            gnt_idx_s = 3'd3;
        end else if (s_wbk_valid[4]) begin
            gnt_idx_s = 3'd4;
        end else if (s_wbk_valid[2]) begin
            gnt_idx_s = 3'd2;
        end else if (s_wbk_valid[0]) begin
            gnt_idx_s = 3'd0;
        end else begin
            gnt_vld_s = 1'b0;
        end
    end
`endif

    // One-hot ready for the selected source. Zero when nothing is valid.
    always_comb begin
        if (gnt_vld_s) begin
            s_wbk_ready = 5'b00001 << gnt_idx_s;
        end else begin
            s_wbk_ready = 5'b00000;
        end
    end

    // Payload mux for the granted source. A constant slice per source keeps
    // the index arithmetic out of the part-selects.
    always_comb begin
        sel_rd_id_s   = 5'd0;
        sel_rd_vld_s  = 1'b0;
        sel_data_s    = 32'd0;
        sel_inst_id_s = '0;
        for (int k = 0; k < 5; k++) begin
            if (gnt_idx_s == 3'(k)) begin
                sel_rd_id_s   = s_wbk_rd_id[k*5 +: 5];
                sel_rd_vld_s  = s_wbk_rd_vld[k];
                sel_data_s    = s_wbk_data[k*32 +: 32];
                sel_inst_id_s = s_wbk_inst_id[k*inst_id_width +: inst_id_width];
            end else begin
                // not the granted source
            end
        end
        // Writes to x0 are dropped, but the instruction still retires.
        sel_wen_s = sel_rd_vld_s && (sel_rd_id_s != 5'd0);
    end

    // Registered write/retire stage. Pulses last one cycle; the payload holds.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            retire_valid   <= 1'b0;
            reg_file_wen   <= 1'b0;
            reg_file_waddr <= 5'd0;
            reg_file_wdata <= 32'd0;
            retire_inst_id <= '0;
            grant_src      <= 3'd0;
        end else begin
            retire_valid <= gnt_vld_s;
            reg_file_wen <= gnt_vld_s && sel_wen_s;
            if (gnt_vld_s) begin
                reg_file_waddr <= sel_rd_id_s;
                reg_file_wdata <= sel_data_s;
                retire_inst_id <= sel_inst_id_s;
                grant_src      <= gnt_idx_s;
            end
        end
    end

endmodule
